// File: rtl/period_scheduler.sv
// Class-period scheduler: turns timer minutes and day-end pulses into period/phase
// state and issues a seat-clear request, over a req/ack handshake, at every period end.
module period_scheduler #(
  parameter int unsigned TIME_W      = 11,
  parameter int unsigned NUM_PERIODS = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned DAY_START   = 0,
  parameter int unsigned PERIOD_LEN  = 50,
  parameter int unsigned BREAK_LEN   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] time_in,
  input  logic              day_end,
  input  logic              clear_ack,
  output logic [IDX_W-1:0]  period_idx,
  output logic              in_class,
  output logic              in_break,
  output logic              day_done,
  output logic              period_start,
  output logic              period_end,
  output logic              clear_req,
  output logic [IDX_W-1:0]  clear_period,
  output logic              overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLASS = 2'd1;
  localparam logic [1:0] ST_BREAK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [TIME_W-1:0] START_T  = TIME_W'(DAY_START);
  localparam logic [TIME_W-1:0] PER_T    = TIME_W'(PERIOD_LEN);
  localparam logic [TIME_W-1:0] BRK_T    = TIME_W'(BREAK_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PERIODS - 1);

  logic [1:0]        state_q, state_d;
  logic [TIME_W-1:0] next_evt_q, next_evt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_class_q, in_class_d;
  logic              in_break_q, in_break_d;
  logic              day_done_q, day_done_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              req_q, req_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              ovr_q, ovr_d;
  logic              match;
  logic              issue;

  assign match = (time_in == next_evt_q);

  // Next-state, boundary tracking and clear handshake.
  always_comb begin
    state_d    = state_q;
    next_evt_d = next_evt_q;
    idx_d      = idx_q;
    start_d    = 1'b0;
    end_d      = 1'b0;
    req_d      = req_q;
    clr_idx_d  = clr_idx_q;
    ovr_d      = ovr_q;
    issue      = 1'b0;

    if (day_end) begin
      idx_d = '0;
      // Timer wrapping to the day start on its own pulse opens period 0 directly.
      if (time_in == START_T) begin
        state_d    = ST_CLASS;
        next_evt_d = START_T + PER_T;
        start_d    = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        next_evt_d = START_T;
      end
    end else if (match) begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_CLASS;
          idx_d      = '0;
          next_evt_d = next_evt_q + PER_T;
          start_d    = 1'b1;
        end
        ST_CLASS: begin
          end_d = 1'b1;
          issue = 1'b1;
          if (idx_q < LAST_IDX) begin
            state_d    = ST_BREAK;
            next_evt_d = next_evt_q + BRK_T;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_BREAK: begin
          state_d    = ST_CLASS;
          idx_d      = idx_q + IDX_W'(1);
          next_evt_d = next_evt_q + PER_T;
          start_d    = 1'b1;
        end
        default: ;
      endcase
    end

    // A new clear is accepted only if the slot is free or being acked this cycle.
    if (issue) begin
      if (!req_q || clear_ack) begin
        req_d     = 1'b1;
        clr_idx_d = idx_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (req_q && clear_ack) begin
      req_d = 1'b0;
    end

    in_class_d = (state_d == ST_CLASS);
    in_break_d = (state_d == ST_BREAK);
    day_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      next_evt_q <= START_T;
      idx_q      <= '0;
      in_class_q <= 1'b0;
      in_break_q <= 1'b0;
      day_done_q <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      req_q      <= 1'b0;
      clr_idx_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_evt_q <= next_evt_d;
      idx_q      <= idx_d;
      in_class_q <= in_class_d;
      in_break_q <= in_break_d;
      day_done_q <= day_done_d;
      start_q    <= start_d;
      end_q      <= end_d;
      req_q      <= req_d;
      clr_idx_q  <= clr_idx_d;
      ovr_q      <= ovr_d;
    end
  end

  assign period_idx   = idx_q;
  assign in_class     = in_class_q;
  assign in_break     = in_break_q;
  assign day_done     = day_done_q;
  assign period_start = start_q;
  assign period_end   = end_q;
  assign clear_req    = req_q;
  assign clear_period = clr_idx_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_period_scheduler.sv
// Bench for period_scheduler: three instances (day start 1, 0, 2046) share stimulus and are
// compared every cycle against a boundary-count reference model, plus directed spot checks.
module tb_period_scheduler;

  localparam int NP = 2;
  localparam int PL = 3;
  localparam int BL = 2;
  localparam int MOD = 2048;
  localparam int NI = 3;
  localparam int DS [NI] = '{1, 0, 2046};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] time_in;
  logic        day_end;
  logic        clear_ack;

  logic o_idx [NI];
  logic o_cls [NI];
  logic o_brk [NI];
  logic o_done[NI];
  logic o_ps  [NI];
  logic o_pe  [NI];
  logic o_req [NI];
  logic o_cp  [NI];
  logic o_ovr [NI];

  int checks = 0;
  int failures = 0;

  // Model: number of boundaries passed today (0 idle, odd in class, even in break, 2*NP done).
  int mb   [NI];
  bit m_ps [NI];
  bit m_pe [NI];
  bit m_req[NI];
  int m_cp [NI];
  bit m_ovr[NI];

  always #5 clk = ~clk;

  period_scheduler #(.TIME_W(11), .NUM_PERIODS(NP), .IDX_W(1), .DAY_START(1),
                     .PERIOD_LEN(PL), .BREAK_LEN(BL)) u0 (
    .clk(clk), .rst_n(rst_n), .time_in(time_in), .day_end(day_end), .clear_ack(clear_ack),
    .period_idx(o_idx[0]), .in_class(o_cls[0]), .in_break(o_brk[0]), .day_done(o_done[0]),
    .period_start(o_ps[0]), .period_end(o_pe[0]), .clear_req(o_req[0]),
    .clear_period(o_cp[0]), .overrun(o_ovr[0]));

  period_scheduler #(.TIME_W(11), .NUM_PERIODS(NP), .IDX_W(1), .DAY_START(0),
                     .PERIOD_LEN(PL), .BREAK_LEN(BL)) u1 (
    .clk(clk), .rst_n(rst_n), .time_in(time_in), .day_end(day_end), .clear_ack(clear_ack),
    .period_idx(o_idx[1]), .in_class(o_cls[1]), .in_break(o_brk[1]), .day_done(o_done[1]),
    .period_start(o_ps[1]), .period_end(o_pe[1]), .clear_req(o_req[1]),
    .clear_period(o_cp[1]), .overrun(o_ovr[1]));

  period_scheduler #(.TIME_W(11), .NUM_PERIODS(NP), .IDX_W(1), .DAY_START(2046),
                     .PERIOD_LEN(PL), .BREAK_LEN(BL)) u2 (
    .clk(clk), .rst_n(rst_n), .time_in(time_in), .day_end(day_end), .clear_ack(clear_ack),
    .period_idx(o_idx[2]), .in_class(o_cls[2]), .in_break(o_brk[2]), .day_done(o_done[2]),
    .period_start(o_ps[2]), .period_end(o_pe[2]), .clear_req(o_req[2]),
    .clear_period(o_cp[2]), .overrun(o_ovr[2]));

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL u%0d.%s observed=%0h expected=%0h t=%0t", k, tag, obs, exp, $time);
    end
  endtask

  function automatic int next_boundary(input int k);
    return (DS[k] + ((mb[k] + 1) / 2) * PL + (mb[k] / 2) * BL) % MOD;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mb[k] = 0; m_ps[k] = 0; m_pe[k] = 0; m_req[k] = 0; m_cp[k] = 0; m_ovr[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int t, input bit de, input bit ack);
    bit issue;
    int iidx;
    issue = 0; iidx = 0;
    m_ps[k] = 0; m_pe[k] = 0;
    if (de) begin
      if (t == DS[k]) begin mb[k] = 1; m_ps[k] = 1; end
      else mb[k] = 0;
    end else if (mb[k] < 2 * NP && t == next_boundary(k)) begin
      if (mb[k] % 2 == 1) begin
        m_pe[k] = 1; issue = 1; iidx = (mb[k] - 1) / 2;
      end else begin
        m_ps[k] = 1;
      end
      mb[k]++;
    end
    if (issue) begin
      if (!m_req[k] || ack) begin m_req[k] = 1; m_cp[k] = iidx; end
      else m_ovr[k] = 1;
    end else if (m_req[k] && ack) begin
      m_req[k] = 0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk(k, "period_idx", 32'(o_idx[k]), (mb[k] == 0) ? 0 : 32'((mb[k] - 1) / 2));
      chk(k, "in_class", 32'(o_cls[k]), 32'(mb[k] % 2 == 1));
      chk(k, "in_break", 32'(o_brk[k]), 32'(mb[k] > 0 && mb[k] < 2 * NP && mb[k] % 2 == 0));
      chk(k, "day_done", 32'(o_done[k]), 32'(mb[k] == 2 * NP));
      chk(k, "period_start", 32'(o_ps[k]), 32'(m_ps[k]));
      chk(k, "period_end", 32'(o_pe[k]), 32'(m_pe[k]));
      chk(k, "clear_req", 32'(o_req[k]), 32'(m_req[k]));
      if (m_req[k]) chk(k, "clear_period", 32'(o_cp[k]), 32'(m_cp[k]));
      chk(k, "overrun", 32'(o_ovr[k]), 32'(m_ovr[k]));
    end
  endtask

  task automatic check_zero();
    for (int k = 0; k < NI; k++) begin
      chk(k, "rst_outputs", {23'd0, o_idx[k], o_cls[k], o_brk[k], o_done[k], o_ps[k],
                             o_pe[k], o_req[k], o_cp[k], o_ovr[k]}, 32'd0);
    end
  endtask

  task automatic step(input logic [10:0] t, input logic de, input logic ack);
    time_in = t; day_end = de; clear_ack = ack;
    for (int k = 0; k < NI; k++) model_step(k, int'(t), de, ack);
    @(posedge clk); #1;
    compare_all();
  endtask

  initial begin
    logic [10:0] tt;
    int r;
    rst_n = 1'b0; time_in = '0; day_end = 1'b0; clear_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    compare_all();
    rst_n = 1'b1;

    // Timer sweep with ack tied high.
    for (int t = 0; t <= 15; t++) begin
      step(11'(t), 1'b0, 1'b1);
      chk(0, "sweep_start", 32'(o_ps[0]), 32'(t == 1 || t == 6));
      chk(0, "sweep_end", 32'(o_pe[0]), 32'(t == 4 || t == 9));
      if (t == 4) chk(0, "sweep_cp0", 32'(o_cp[0]), 0);
      if (t == 9) chk(0, "sweep_cp1", 32'(o_cp[0]), 1);
      chk(0, "sweep_done", 32'(o_done[0]), 32'(t >= 9));
    end

    // Handshake: hold ack low five cycles after the first period end, then pulse it.
    step(11'd20, 1'b1, 1'b0);
    for (int t = 0; t <= 4; t++) step(11'(t), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(11'd5, 1'b0, 1'b0);
      chk(0, "hs_req_held", 32'(o_req[0]), 1);
      chk(0, "hs_cp_stable", 32'(o_cp[0]), 0);
    end
    step(11'd5, 1'b0, 1'b1);
    chk(0, "hs_req_drop", 32'(o_req[0]), 0);
    for (int t = 6; t <= 12; t++) step(11'(t), 1'b0, 1'b0);

    // Asynchronous reset with a request pending.
    chk(0, "pre_rst_req", 32'(o_req[0]), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Overrun: ack low for a whole day.
    for (int t = 0; t <= 12; t++) begin
      step(11'(t), 1'b0, 1'b0);
      if (t == 9) begin
        chk(0, "ovr_cp", 32'(o_cp[0]), 0);
        chk(0, "ovr_flag", 32'(o_ovr[0]), 1);
      end
    end
    step(11'd20, 1'b1, 1'b0);
    chk(0, "ovr_sticky", 32'(o_ovr[0]), 1);

    // Day wrap on the DAY_START=0 instance.
    step(11'd5, 1'b0, 1'b0);
    step(11'd0, 1'b1, 1'b0);
    chk(1, "wrap_class", 32'(o_cls[1]), 1);
    chk(1, "wrap_idx", 32'(o_idx[1]), 0);
    chk(1, "wrap_start", 32'(o_ps[1]), 1);

    // Day end in the middle of period 0.
    step(11'd30, 1'b1, 1'b1);
    step(11'd0, 1'b0, 1'b1);
    step(11'd1, 1'b0, 1'b1);
    step(11'd2, 1'b1, 1'b1);
    chk(0, "mid_class", 32'(o_cls[0]), 0);
    chk(0, "mid_end", 32'(o_pe[0]), 0);
    for (int t = 3; t <= 5; t++) begin
      step(11'(t), 1'b0, 1'b1);
      chk(0, "mid_no_end", 32'(o_pe[0]), 0);
      chk(0, "mid_no_req", 32'(o_req[0]), 0);
    end

    // Minute counter wrap-around on the DAY_START=2046 instance.
    step(11'd100, 1'b1, 1'b1);
    for (int t = 2040; t < 2048 + 7; t++) begin
      step(11'(t % MOD), 1'b0, 1'b1);
      if (t == 2046) chk(2, "wrap_start", 32'(o_ps[2]), 1);
      if (t == 2049) begin
        chk(2, "wrap_end", 32'(o_pe[2]), 1);
        chk(2, "wrap_cp", 32'(o_cp[2]), 0);
      end
    end

    // Randomized traffic against the model.
    tt = 11'd0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(99, 0));
      if (r < 85)      tt = tt + 11'd1;
      else if (r < 92) tt = 11'($urandom_range(15, 0));
      else if (r < 96) tt = 11'(2040 + $urandom_range(7, 0));
      else             tt = 11'($urandom_range(2047, 0));
      step(tt, ($urandom_range(49, 0) == 0), 1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
